// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared constants for the key event generator: FSM state encoding and the
// default timing values for a 100 MHz system clock.
// ---------------------------------------------------------------------------
package key_pkg;

    // FSM state encoding. 2'd3 is never entered; the FSM recovers from it
    // to idle.
    localparam logic [1:0] KS_IDLE   = 2'd0;
    localparam logic [1:0] KS_HOLD   = 2'd1;
    localparam logic [1:0] KS_REPEAT = 2'd2;

    // Default timing at 100 MHz: 0.5 s to long-press, 0.1 s between repeats.
    localparam int KEY_LONG_100M   = 50_000_000;
    localparam int KEY_REPEAT_100M = 10_000_000;

    // Saturation limit of the repeat counter.
    localparam logic [7:0] KEY_RCNT_MAX = 8'hFF;

endpackage

// File: rtl/key_event.sv
// ---------------------------------------------------------------------------
// key_event
// Turns the debounced key level into single-cycle key events: press,
// release, long-press and auto-repeat. Also reports a held flag and a
// saturating count of repeat events in the current hold.
//
// Ports:
//   clk           in   system clock
//   rstn          in   asynchronous active-low reset
//   btn           in   debounced key level, already synchronous to clk
//   press_pulse   out  one-cycle pulse on the press edge
//   release_pulse out  one-cycle pulse on the release edge
//   long_pulse    out  one-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_pulse  out  one-cycle pulse every REPEAT_CYCLES in repeat mode
//   held          out  high while the FSM is not idle
//   repeat_count  out  repeat pulses in the current hold, saturates at 255
//
// All outputs are registered. LONG_CYCLES and REPEAT_CYCLES must be >= 2.
// ---------------------------------------------------------------------------
module key_event
    import key_pkg::*;
#(
    parameter int LONG_CYCLES   = KEY_LONG_100M,
    parameter int REPEAT_CYCLES = KEY_REPEAT_100M
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] repeat_count
);

    // One counter serves both the long-press and the repeat interval, so it
    // only has to reach the larger of the two terminal values.
    localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES);

    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic          r_repeat;
    logic          r_held;
    logic [7:0]    r_rcnt;

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_press;
    logic          w_release;
    logic          w_long;
    logic          w_repeat;
    logic [7:0]    w_rcnt_nxt;

    // btn is tested first in every non-idle state, so a release always wins
    // over a long or repeat event due on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        w_rcnt_nxt  = r_rcnt;

        case (r_state)
            KS_IDLE: begin
                if (btn) begin
                    w_press     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_rcnt_nxt  = 8'd0;
                    w_state_nxt = KS_HOLD;
                end
            end

            KS_HOLD: begin
                if (!btn) begin
                    w_release   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = KS_IDLE;
                end else if (r_cnt == LONG_LAST) begin
                    w_long      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = KS_REPEAT;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end

            KS_REPEAT: begin
                if (!btn) begin
                    // repeat_count is left alone so it can be read after release.
                    w_release   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = KS_IDLE;
                end else if (r_cnt == REPEAT_LAST) begin
                    w_repeat    = 1'b1;
                    w_cnt_nxt   = '0;
                    if (r_rcnt != KEY_RCNT_MAX) begin
                        w_rcnt_nxt = r_rcnt + 8'd1;
                    end
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end

            default: begin
                w_state_nxt = KS_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= KS_IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
            r_rcnt    <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press;
            r_release <= w_release;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
            // Registered from the next state so it rises with press_pulse
            // and falls with release_pulse.
            r_held    <= (w_state_nxt != KS_IDLE);
            r_rcnt    <= w_rcnt_nxt;
        end
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;
    assign repeat_pulse  = r_repeat;
    assign held          = r_held;
    assign repeat_count  = r_rcnt;

endmodule

// File: tb/tb_key_event.sv
// ---------------------------------------------------------------------------
// tb_key_event
// Directed bench for key_event. Instance A uses LONG=8/REPEAT=4, instance B
// uses LONG=2/REPEAT=2. Inputs change 1 time unit after the rising edge and
// outputs are sampled at that same point, so each step reflects exactly one
// clock edge. Edge numbers count from the press edge (edge 0).
// ---------------------------------------------------------------------------
module tb_key_event;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn_a, btn_a;
    logic       press_a, release_a, long_a, repeat_a, held_a;
    logic [7:0] rcnt_a;

    logic       rstn_b, btn_b;
    logic       press_b, release_b, long_b, repeat_b, held_b;
    logic [7:0] rcnt_b;

    int checks = 0;
    int errors = 0;

    key_event #(.LONG_CYCLES(8), .REPEAT_CYCLES(4)) u_dut_a (
        .clk           (clk),
        .rstn          (rstn_a),
        .btn           (btn_a),
        .press_pulse   (press_a),
        .release_pulse (release_a),
        .long_pulse    (long_a),
        .repeat_pulse  (repeat_a),
        .held          (held_a),
        .repeat_count  (rcnt_a)
    );

    key_event #(.LONG_CYCLES(2), .REPEAT_CYCLES(2)) u_dut_b (
        .clk           (clk),
        .rstn          (rstn_b),
        .btn           (btn_b),
        .press_pulse   (press_b),
        .release_pulse (release_b),
        .long_pulse    (long_b),
        .repeat_pulse  (repeat_b),
        .held          (held_b),
        .repeat_count  (rcnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check every output of instance A against expected values.
    task automatic chk_a(input string tag, input logic p, input logic r, input logic l,
                         input logic rp, input logic h, input logic [7:0] c);
        chk({tag, ".press"},   32'(press_a),   32'(p));
        chk({tag, ".release"}, 32'(release_a), 32'(r));
        chk({tag, ".long"},    32'(long_a),    32'(l));
        chk({tag, ".repeat"},  32'(repeat_a),  32'(rp));
        chk({tag, ".held"},    32'(held_a),    32'(h));
        chk({tag, ".rcnt"},    32'(rcnt_a),    32'(c));
    endtask

    task automatic chk_b(input string tag, input logic p, input logic r, input logic l,
                         input logic rp, input logic h, input logic [7:0] c);
        chk({tag, ".press"},   32'(press_b),   32'(p));
        chk({tag, ".release"}, 32'(release_b), 32'(r));
        chk({tag, ".long"},    32'(long_b),    32'(l));
        chk({tag, ".repeat"},  32'(repeat_b),  32'(rp));
        chk({tag, ".held"},    32'(held_b),    32'(h));
        chk({tag, ".rcnt"},    32'(rcnt_b),    32'(c));
    endtask

    initial begin
        logic [7:0] exp_c;
        int         k;

        rstn_a = 1'b0;
        btn_a  = 1'b1;
        rstn_b = 1'b0;
        btn_b  = 1'b0;

        // Reset with btn high: everything stays 0.
        tick();
        chk_a("rst0", 0, 0, 0, 0, 0, 8'd0);
        tick();
        chk_a("rst1", 0, 0, 0, 0, 0, 8'd0);
        chk_b("rstb", 0, 0, 0, 0, 0, 8'd0);

        // Release reset with btn high: first edge is a press.
        rstn_a = 1'b1;
        tick();
        chk_a("rstrel_press", 1, 0, 0, 0, 1, 8'd0);

        // One-cycle btn high: release on the following edge.
        btn_a = 1'b0;
        tick();
        chk_a("onecyc_rel", 0, 1, 0, 0, 0, 8'd0);
        tick();
        chk_a("onecyc_idle", 0, 0, 0, 0, 0, 8'd0);

        // Short press: high for edges 0..4, low at 5.
        for (int e = 0; e <= 5; e++) begin
            btn_a = (e < 5);
            tick();
            chk_a($sformatf("short_e%0d", e), e == 0, e == 5, 0, 0, e < 5, 8'd0);
        end
        tick();
        chk_a("short_idle", 0, 0, 0, 0, 0, 8'd0);

        // Long hold: high for edges 0..19, low at 20.
        for (int e = 0; e <= 20; e++) begin
            btn_a = (e < 20);
            tick();
            exp_c = (e >= 16) ? 8'd2 : (e >= 12) ? 8'd1 : 8'd0;
            chk_a($sformatf("long_e%0d", e), e == 0, e == 20, e == 8,
                  (e == 12) || (e == 16), e < 20, exp_c);
        end
        tick();
        chk_a("long_idle", 0, 0, 0, 0, 0, 8'd2);

        // Release on the edge that would fire long: no long_pulse.
        for (int e = 0; e <= 8; e++) begin
            btn_a = (e < 8);
            tick();
            chk_a($sformatf("lbound_e%0d", e), e == 0, e == 8, 0, 0, e < 8, 8'd0);
        end
        tick();
        chk_a("lbound_idle", 0, 0, 0, 0, 0, 8'd0);

        // Release on the edge that would fire the first repeat (edge 12).
        for (int e = 0; e <= 12; e++) begin
            btn_a = (e < 12);
            tick();
            chk_a($sformatf("rbound_e%0d", e), e == 0, e == 12, e == 8, 0, e < 12, 8'd0);
        end

        // Reset mid-REPEAT at edge 14 of a hold.
        btn_a = 1'b1;
        for (int e = 0; e <= 14; e++) begin
            tick();
        end
        chk_a("midrst_pre", 0, 0, 0, 0, 1, 8'd1);
        rstn_a = 1'b0;
        #1;
        chk_a("midrst_async", 0, 0, 0, 0, 0, 8'd0);
        btn_a = 1'b0;
        tick();
        chk_a("midrst_hold0", 0, 0, 0, 0, 0, 8'd0);
        btn_a = 1'b1;
        tick();
        chk_a("midrst_hold1", 0, 0, 0, 0, 0, 8'd0);
        rstn_a = 1'b1;
        tick();
        chk_a("midrst_press", 1, 0, 0, 0, 1, 8'd0);
        btn_a = 1'b0;
        tick();
        chk_a("midrst_rel", 0, 1, 0, 0, 0, 8'd0);

        // Saturation on instance B: LONG=2, REPEAT=2, held for 700 edges.
        rstn_b = 1'b1;
        tick();
        chk_b("sat_idle", 0, 0, 0, 0, 0, 8'd0);
        btn_b = 1'b1;
        for (int e = 0; e < 700; e++) begin
            tick();
            k = (e >= 4) ? (e - 2) / 2 : 0;
            exp_c = (k > 255) ? 8'd255 : 8'(k);
            chk_b($sformatf("sat_e%0d", e), e == 0, 0, e == 2,
                  (e >= 4) && (e % 2 == 0), 1, exp_c);
        end
        btn_b = 1'b0;
        tick();
        chk_b("sat_rel", 0, 1, 0, 0, 0, 8'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
